iic_slave: RTL
==============

# iic_slave

I2C target (responder) that answers the team's `iic_driver` master on the same two-wire bus. It decodes START/STOP, matches a 7-bit device address, and accepts an 8-bit register address. It then writes or reads single or burst bytes through a simple register-bank port. It is used as an on-chip register endpoint and as the bus-functional partner for master verification.

## Interface
- `DEV_ADDR`, default 7'b1101000: 7-bit device address this target answers to.
- `clk`  in  1  system clock; SCL is oversampled on it.
- `rst`  in  1  synchronous, active-high reset.
- `iic_scl`  in  1  bus SCL, asynchronous to `clk`.
- `iic_sda_i`  in  1  bus SDA sampled value, asynchronous to `clk`.
- `iic_sda_o`  out  1  SDA value to drive when `iic_sda_ctrl`=1.
- `iic_sda_ctrl`  out  1  1 = block drives `iic_sda_o` onto SDA; 0 = released (high-Z).
- `reg_addr`  out  8  current register address.
- `reg_wdata`  out  8  write byte; valid while `reg_wr`=1.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read-request strobe.
- `reg_rdata`  in  8  read byte; must be valid one `clk` after `reg_rd`.
- `busy`  out  1  high from an address-matched START until STOP, NACK exit or mismatch.

## Operation
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer plus a history flop. Edges and levels are taken from synchronized values only.
- START: SDA falls while SCL is high. Valid in any state, which covers repeated START. Effect: go to DEV, bit counter = 0, release SDA.
- STOP: SDA rises while SCL is high. Valid in any state. Effect: go to IDLE, release SDA, `busy`=0.
- Received bits are shifted MSB-first on each detected SCL rise.
- Outgoing SDA changes only on a detected SCL fall.
- States and transitions:
  - IDLE: wait for START.
  - DEV: shift 8 bits.
    - Upper 7 bits ≠ `DEV_ADDR` → IGNORE (SDA released, wait for START/STOP).
    - Match → DEV_ACK; `busy`=1.
  - DEV_ACK: drive 0 for the 9th clock. Next state: R/W=0 → ADDR; R/W=1 → RDATA. On the R/W=1 path, `reg_rd` pulses on entry.
  - ADDR: shift 8 bits → ADDR_ACK; `reg_addr` is loaded on the 8th rise.
  - ADDR_ACK: drive 0 → WDATA.
  - WDATA: shift 8 bits. On the 8th rise: `reg_wdata` = byte, `reg_wr` pulses once → WDATA_ACK.
  - WDATA_ACK: drive 0 → WDATA. `reg_addr` increments at the end of the ACK clock, 8'hFF wraps to 8'h00.
  - RDATA: latch `reg_rdata` into the shift register the cycle after `reg_rd`. Drive MSB first, 8 bits. Release at the 8th fall → RDATA_ACK.
  - RDATA_ACK: sample master ACK on the 9th rise.
    - ACK (0): `reg_addr` +1 (wrap), pulse `reg_rd` → RDATA.
    - NACK (1): → IGNORE until STOP/START.
- Data bits are driven as `iic_sda_ctrl`=1 with `iic_sda_o` = bit value. At all other times `iic_sda_ctrl`=0.

## Timing
- Reset values: `iic_sda_ctrl`=0, `iic_sda_o`=1, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=0, state IDLE.
- Reset asserted mid-transfer wins on the same edge. SDA is released immediately and the block resumes only at the next START.
- Latency from a bus edge to internal detection is 3 `clk`. The SCL low phase must be ≥ 6 `clk`, which leaves room for the SDA setup after the drive change.
- ACK drive asserts 3 `clk` after the 8th SCL fall reaches the pin. It releases 3 `clk` after the 9th fall.
- `reg_wr` pulse occurs 3 `clk` after the 8th SCL rise of a write byte.
- `reg_rd` pulses are spaced ≥ 1 byte apart. `reg_rdata` is captured exactly 1 `clk` after `reg_rd`.
- SDA toggling while SCL is low is never treated as START or STOP.
- If START/STOP and an SCL edge are detected in the same cycle, START/STOP takes priority.
- A STOP mid-byte discards the partial byte: no `reg_wr` and no address increment.

## Test plan
- Write: START, 0xD0, 0x28, 0xA5, STOP. Required: three ACKs (SDA driven 0 on each 9th clock), one `reg_wr` with `reg_addr`=0x28 and `reg_wdata`=0xA5, `busy` returns to 0 after STOP.
- Read: START, 0xD0, 0x28, repeated START, 0xD1, then master NACK, with the bank returning 0x3C. Required: SDA bit sequence 0,0,1,1,1,1,0,0, one `reg_rd`, then SDA released and state IDLE after STOP.
- Address mismatch: START, 0xA0. Required: SDA never driven, no strobes, `busy`=0 throughout.
- Burst write with wrap: address 0xFE, data 0x11,0x22,0x33. Required: writes land at 0xFE, 0xFF, 0x00.
- Burst read: two master ACKs then NACK. Required: three `reg_rd` pulses at consecutive addresses and correct bytes on SDA.
- Abort cases:
  - STOP after 4 data bits. Required: no `reg_wr`.
  - `rst` pulsed during the ACK phase. Required: `iic_sda_ctrl`=0 on the next `clk`, all outputs at reset values.

Source files
------------

// File: rtl/iic_slave.sv
// I2C target: START/STOP decode, 7-bit device match, 8-bit register address,
// single and burst byte writes/reads through a simple register-bank port.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b1101000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iic_scl,
  input  logic       iic_sda_i,
  output logic       iic_sda_o,
  output logic       iic_sda_ctrl,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_ADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_q, scl_d, sda_q, sda_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic        ctrl_q, ctrl_d, o_q, o_d;
  logic        wr_q, wr_d, rd_q, rd_d, ld_q, ld_d;
  logic        busy_q, busy_d, rw_q, rw_d;

  logic        scl_rise, scl_fall, start_c, stop_c, sda_in;
  logic [7:0]  byte_in;

  // bit 1 is the synchronized level, bit 2 the previous sample
  assign scl_d    = {scl_q[1:0], iic_scl};
  assign sda_d    = {sda_q[1:0], iic_sda_i};
  assign sda_in   = sda_q[1];
  assign byte_in  = {sh_q[6:0], sda_in};
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_c   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    o_d     = o_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ld_d    = rd_q;
    if (ld_q) sh_d = reg_rdata;
    if (start_c) begin
      state_d = S_DEV;
      cnt_d   = 4'd0;
      ctrl_d  = 1'b0;
      o_d     = 1'b1;
    end else if (stop_c) begin
      state_d = S_IDLE;
      ctrl_d  = 1'b0;
      o_d     = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (sh_q[6:0] == DEV_ADDR) begin
              state_d = S_DEV_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_in;
              rd_d    = sda_in;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_DEV_ACK, S_ADDR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!ctrl_q) begin
            ctrl_d = 1'b1;
            o_d    = 1'b0;
          end else begin
            ctrl_d = 1'b0;
            o_d    = 1'b1;
            cnt_d  = 4'd0;
            if (state_q == S_DEV_ACK) begin
              state_d = S_ADDR;
              // read data was fetched during the ACK clock; first bit goes out now
              if (rw_q) begin
                state_d = S_RDATA;
                ctrl_d  = 1'b1;
                o_d     = sh_q[7];
                sh_d    = {sh_q[6:0], 1'b0};
                cnt_d   = 4'd1;
              end
            end else begin
              state_d = S_WDATA;
              if (state_q == S_WDATA_ACK) addr_d = addr_q + 8'd1;
            end
          end
        end
        S_ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            addr_d  = byte_in;
            state_d = S_ADDR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            wdata_d = byte_in;
            wr_d    = 1'b1;
            state_d = S_WDATA_ACK;
          end
        end
        S_RDATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            ctrl_d  = 1'b0;
            o_d     = 1'b1;
            state_d = S_RDATA_ACK;
          end else begin
            ctrl_d = 1'b1;
            o_d    = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
            cnt_d  = cnt_q + 4'd1;
          end
        end
        S_RDATA_ACK: if (scl_rise) begin
          if (!sda_in) begin
            state_d = S_RDATA;
            cnt_d   = 4'd0;
            addr_d  = addr_q + 8'd1;
            rd_d    = 1'b1;
          end else begin
            state_d = S_IGNORE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      sh_q    <= 8'h00;
      cnt_q   <= 4'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      ctrl_q  <= 1'b0;
      o_q     <= 1'b1;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      o_q     <= o_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
    end
  end

  assign iic_sda_o    = o_q;
  assign iic_sda_ctrl = ctrl_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_wr       = wr_q;
  assign reg_rd       = rd_q;
  assign busy         = busy_q;

endmodule
